// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - execute-stage sequencer: R-type decode, ALU issue, HI/LO and iterative mul/div
module exec_sequencer #(
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    output logic [5:0]       alu_op,
    output logic [31:0]      alu_insn,
    output logic [WIDTH-1:0] alu_rs,
    output logic [WIDTH-1:0] alu_rt,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_MULDIV, S_RESP} state_t;
    typedef enum logic [2:0] {C_ALU, C_MUL, C_DIV, C_MFHI, C_MFLO, C_MTHI, C_MTLO, C_ILL} cls_t;

    localparam logic [4:0] LAT    = 5'(ALU_LATENCY);
    localparam logic [4:0] LAT_M1 = 5'(ALU_LATENCY - 1);

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        out_valid_q, out_valid_d;
    logic        out_illegal_q, out_illegal_d;
    logic [31:0] out_data_q, out_data_d;
    logic [5:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_insn_q, alu_insn_d;
    logic [31:0] alu_rs_q, alu_rs_d;
    logic [31:0] alu_rt_q, alu_rt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] md_hi_q, md_hi_d;
    logic [31:0] md_lo_q, md_lo_d;
    logic [31:0] md_opnd_q, md_opnd_d;
    logic        md_div_q, md_div_d;
    logic        md_negq_q, md_negq_d;
    logic        md_negr_q, md_negr_d;
    logic        md_zero_q, md_zero_d;

    cls_t        dec_cls;
    logic [5:0]  dec_op;
    logic        dec_signed;
    logic [31:0] abs_rs, abs_rt;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic        div_ge;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod;

    always_comb begin
        dec_cls    = C_ILL;
        dec_op     = 6'd0;
        dec_signed = 1'b0;
        if (in_insn[31:26] == 6'b000000) begin
            case (in_insn[5:0])
                6'h20: begin dec_cls = C_ALU; dec_op = 6'd1;  end
                6'h21: begin dec_cls = C_ALU; dec_op = 6'd2;  end
                6'h22: begin dec_cls = C_ALU; dec_op = 6'd3;  end
                6'h23: begin dec_cls = C_ALU; dec_op = 6'd4;  end
                6'h24: begin dec_cls = C_ALU; dec_op = 6'd5;  end
                6'h25: begin dec_cls = C_ALU; dec_op = 6'd6;  end
                6'h26: begin dec_cls = C_ALU; dec_op = 6'd7;  end
                6'h27: begin dec_cls = C_ALU; dec_op = 6'd8;  end
                6'h2A: begin dec_cls = C_ALU; dec_op = 6'd9;  end
                6'h2B: begin dec_cls = C_ALU; dec_op = 6'd10; end
                6'h00: begin dec_cls = C_ALU; dec_op = 6'd11; end
                6'h02: begin dec_cls = C_ALU; dec_op = 6'd12; end
                6'h03: begin dec_cls = C_ALU; dec_op = 6'd13; end
                6'h18: begin dec_cls = C_MUL; dec_signed = 1'b1; end
                6'h19: dec_cls = C_MUL;
                6'h1A: begin dec_cls = C_DIV; dec_signed = 1'b1; end
                6'h1B: dec_cls = C_DIV;
                6'h10: dec_cls = C_MFHI;
                6'h11: dec_cls = C_MTHI;
                6'h12: dec_cls = C_MFLO;
                6'h13: dec_cls = C_MTLO;
                default: dec_cls = C_ILL;
            endcase
        end
    end

    // Signed mul/div work on magnitudes; signs are fixed up on the final iteration.
    assign abs_rs = (dec_signed && in_rs[31]) ? -in_rs : in_rs;
    assign abs_rt = (dec_signed && in_rt[31]) ? -in_rt : in_rt;

    // Multiply: {md_hi, md_lo} is the partial product with the multiplier shifting out of md_lo.
    assign mul_sum = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_opnd_q} : 33'd0);
    // Divide: md_hi is the partial remainder, md_lo shifts dividend bits out and quotient bits in.
    assign div_shift = {md_hi_q, md_lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, md_opnd_q};
    assign div_diff  = div_shift - {1'b0, md_opnd_q};

    always_comb begin
        if (md_div_q) begin
            step_hi = div_ge ? div_diff[31:0] : div_shift[31:0];
            step_lo = {md_lo_q[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], md_lo_q[31:1]};
        end
    end

    assign prod = {step_hi, step_lo};

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_illegal_d = out_illegal_q;
        out_data_d    = out_data_q;
        alu_op_d      = alu_op_q;
        alu_insn_d    = alu_insn_q;
        alu_rs_d      = alu_rs_q;
        alu_rt_d      = alu_rt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        cnt_d         = cnt_q;
        md_hi_d       = md_hi_q;
        md_lo_d       = md_lo_q;
        md_opnd_d     = md_opnd_q;
        md_div_d      = md_div_q;
        md_negq_d     = md_negq_q;
        md_negr_d     = md_negr_q;
        md_zero_d     = md_zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    case (dec_cls)
                        C_ALU: begin
                            state_d    = S_ISSUE;
                            alu_op_d   = dec_op;
                            alu_insn_d = in_insn;
                            alu_rs_d   = in_rs;
                            alu_rt_d   = in_rt;
                        end
                        C_MUL, C_DIV: begin
                            state_d   = S_MULDIV;
                            cnt_d     = 5'd0;
                            md_div_d  = (dec_cls == C_DIV);
                            md_negq_d = dec_signed && (in_rs[31] ^ in_rt[31]);
                            md_negr_d = dec_signed && in_rs[31];
                            md_hi_d   = 32'd0;
                            md_zero_d = 1'b0;
                            if (dec_cls == C_MUL) begin
                                md_lo_d   = abs_rt;
                                md_opnd_d = abs_rs;
                            end else begin
                                md_lo_d   = abs_rs;
                                md_opnd_d = abs_rt;
                                if (in_rt == 32'd0) begin
                                    md_zero_d = 1'b1;
                                    md_hi_d   = in_rs;
                                    md_lo_d   = 32'hFFFF_FFFF;
                                end
                            end
                        end
                        C_MFHI: begin
                            state_d       = S_RESP;
                            out_valid_d   = 1'b1;
                            out_illegal_d = 1'b0;
                            out_data_d    = hi_q;
                        end
                        C_MFLO: begin
                            state_d       = S_RESP;
                            out_valid_d   = 1'b1;
                            out_illegal_d = 1'b0;
                            out_data_d    = lo_q;
                        end
                        C_MTHI: hi_d = in_rs;
                        C_MTLO: lo_d = in_rs;
                        default: begin
                            state_d       = S_RESP;
                            out_valid_d   = 1'b1;
                            out_illegal_d = 1'b1;
                            out_data_d    = 32'd0;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = 5'd0;
            end
            S_WAIT: begin
                // alu_op drops one cycle before capture so it is held exactly ALU_LATENCY+1 cycles.
                if (cnt_q == LAT) begin
                    state_d       = S_RESP;
                    out_valid_d   = 1'b1;
                    out_illegal_d = 1'b0;
                    out_data_d    = alu_result;
                    cnt_d         = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAT_M1) begin
                        alu_op_d = 6'd0;
                    end
                end
            end
            S_MULDIV: begin
                if (md_zero_q) begin
                    hi_d    = md_hi_q;
                    lo_d    = md_lo_q;
                    state_d = S_IDLE;
                end else if (cnt_q == 5'd31) begin
                    if (md_div_q) begin
                        lo_d = md_negq_q ? -step_lo : step_lo;
                        hi_d = md_negr_q ? -step_hi : step_hi;
                    end else begin
                        {hi_d, lo_d} = md_negq_q ? -prod : prod;
                    end
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    md_hi_d = step_hi;
                    md_lo_d = step_lo;
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d       = S_IDLE;
                    out_valid_d   = 1'b0;
                    out_illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            out_data_q    <= 32'd0;
            alu_op_q      <= 6'd0;
            alu_insn_q    <= 32'd0;
            alu_rs_q      <= 32'd0;
            alu_rt_q      <= 32'd0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            cnt_q         <= 5'd0;
            md_hi_q       <= 32'd0;
            md_lo_q       <= 32'd0;
            md_opnd_q     <= 32'd0;
            md_div_q      <= 1'b0;
            md_negq_q     <= 1'b0;
            md_negr_q     <= 1'b0;
            md_zero_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_illegal_q <= out_illegal_d;
            out_data_q    <= out_data_d;
            alu_op_q      <= alu_op_d;
            alu_insn_q    <= alu_insn_d;
            alu_rs_q      <= alu_rs_d;
            alu_rt_q      <= alu_rt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            cnt_q         <= cnt_d;
            md_hi_q       <= md_hi_d;
            md_lo_q       <= md_lo_d;
            md_opnd_q     <= md_opnd_d;
            md_div_q      <= md_div_d;
            md_negq_q     <= md_negq_d;
            md_negr_q     <= md_negr_d;
            md_zero_q     <= md_zero_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_illegal = out_illegal_q;
    assign out_data    = out_data_q;
    assign alu_op      = alu_op_q;
    assign alu_insn    = alu_insn_q;
    assign alu_rs      = alu_rs_q;
    assign alu_rt      = alu_rt_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer with a 1-cycle stub ALU
module tb_exec_sequencer;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [5:0]  alu_op;
    logic [31:0] alu_insn;
    logic [31:0] alu_rs;
    logic [31:0] alu_rt;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_illegal;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADD     = 32'h0000_0020;
    localparam logic [31:0] I_MULT    = 32'h0000_0018;
    localparam logic [31:0] I_MULTU   = 32'h0000_0019;
    localparam logic [31:0] I_DIV     = 32'h0000_001A;
    localparam logic [31:0] I_DIVU    = 32'h0000_001B;
    localparam logic [31:0] I_MFHI    = 32'h0000_0010;
    localparam logic [31:0] I_MTHI    = 32'h0000_0011;
    localparam logic [31:0] I_MFLO    = 32'h0000_0012;
    localparam logic [31:0] I_MTLO    = 32'h0000_0013;
    localparam logic [31:0] I_ADDI    = 32'h2000_0000;
    localparam logic [31:0] I_SYSCALL = 32'h0000_000C;

    exec_sequencer #(.WIDTH(32), .ALU_LATENCY(1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_insn     (in_insn),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .alu_op      (alu_op),
        .alu_insn    (alu_insn),
        .alu_rs      (alu_rs),
        .alu_rt      (alu_rt),
        .alu_result  (alu_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_illegal (out_illegal),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        alu_result <= (alu_op == 6'd1) ? alu_rs + alu_rt : 32'd0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] insn, input logic [31:0] rs, input logic [31:0] rt);
        int n = 0;
        in_valid = 1'b1;
        in_insn  = insn;
        in_rs    = rs;
        in_rt    = rt;
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic wait_resp(input string tag, input logic [31:0] exp_data, input logic exp_ill);
        int n = 0;
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clock);
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_done"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_insn   = 32'd0;
        in_rs     = 32'd0;
        in_rt     = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_alu_op", {26'd0, alu_op}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // Seed HI so an aborted multiply visibly clears it.
        send(I_MTHI, 32'h1234_5678, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        send(I_MULT, 32'd5, 32'd6);
        repeat (9) @(negedge clock);
        check("md_busy_c10", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // ADD through the stub ALU with exact cycle timing.
        send(I_ADD, 32'd5, 32'd7);
        check("add_op_c1", {26'd0, alu_op}, 32'd1);
        check("add_rs", alu_rs, 32'd5);
        check("add_rt", alu_rt, 32'd7);
        check("add_insn", alu_insn, I_ADD);
        check("add_ov_c1", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        check("add_op_c2", {26'd0, alu_op}, 32'd1);
        check("add_ov_c2", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        check("add_op_c3", {26'd0, alu_op}, 32'd0);
        check("add_ov_c3", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            check("add_hold_valid", {31'd0, out_valid}, 32'd1);
            check("add_hold_data", out_data, 32'd12);
            check("add_hold_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clock);
        end
        wait_resp("add", 32'd12, 1'b0);

        send(I_MULT, 32'hFFFF_FFFD, 32'h7FFF_FFFF);
        wait_idle(cyc);
        check("mult_cycles", cyc, 32'd32);
        check("mult_hi", hi, 32'hFFFF_FFFE);
        check("mult_lo", lo, 32'h8000_0003);
        send(I_MFHI, 32'd0, 32'd0);
        wait_resp("mfhi", 32'hFFFF_FFFE, 1'b0);
        send(I_MFLO, 32'd0, 32'd0);
        wait_resp("mflo", 32'h8000_0003, 1'b0);

        send(I_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(cyc);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        send(I_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        check("div_cycles", cyc, 32'd32);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        send(I_DIVU, 32'd100, 32'd7);
        wait_idle(cyc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        send(I_DIVU, 32'd100, 32'd0);
        wait_idle(cyc);
        check("div0_cycles", cyc, 32'd1);
        check("div0_hi", hi, 32'd100);
        check("div0_lo", lo, 32'hFFFF_FFFF);

        send(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);

        send(I_MTLO, 32'hDEAD_BEEF, 32'd0);
        check("mtlo_ready", {31'd0, in_ready}, 32'd1);
        send(I_MFLO, 32'd0, 32'd0);
        wait_resp("mtlo_mflo", 32'hDEAD_BEEF, 1'b0);

        send(I_ADDI, 32'd1, 32'd2);
        check("addi_alu_op", {26'd0, alu_op}, 32'd0);
        wait_resp("addi", 32'd0, 1'b1);
        send(I_SYSCALL, 32'd1, 32'd2);
        check("sys_alu_op", {26'd0, alu_op}, 32'd0);
        wait_resp("syscall", 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
